telemetry_tx: RTL
=================

// Module: telemetry_tx
// PURPOSE
//  Transmit end of the eBike telemetry link. It periodically snapshots battery, current and torque.
//  It frames the snapshot as an 8-byte packet and serialises it over a UART (8N1) on TX.
//  The far end is a UART receiver plus a byte decoder in the bench/monitor.
//  Sits in eBike next to the A2D interface, which supplies the 12-bit readings.
// PARAMETERS
//  BAUD_DIV  5208      clocks per UART bit (50MHz/9600); must be >= 2
//  PERIOD    1048576   clocks between packet launch opportunities; must be >= 2
// PORTS
//  clk      in   1   system clock, all logic on posedge
//  rst      in   1   asynchronous, active-high reset
//  en       in   1   1 = launch packets on period ticks; 0 = no new packets
//  batt     in   12  battery reading
//  curr     in   12  motor current reading
//  torque   in   12  pedal torque reading
//  TX       out  1   UART serial out, idles high
//  busy     out  1   1 while a packet is being transmitted
//  pkt_done out  1   one-clock pulse when the last stop bit of a packet completes
// BEHAVIOUR
//  Reset: TX=1, busy=0, pkt_done=0, timer=0, baud cnt=0, bit cnt=0, byte idx=0, state IDLE.
//   Reset forces all of these immediately, with no clock edge; a packet in flight is abandoned.
//  Timer: free-running 0..PERIOD-1, wraps to 0. tick = (timer==PERIOD-1), 1 cycle.
//   The timer never pauses for busy or en.
//  Launch: tick & en & state==IDLE, sampled at posedge N. At posedge N:
//   - batt/curr/torque are captured into snapshot regs, all 3 the same cycle.
//   - state becomes XMIT, busy=1, TX=0 (start bit of byte 0).
//  Dropped ticks: a tick while XMIT, or with en=0, is dropped. It is not queued.
//  Packet byte order, idx 0..7:
//   AA, 55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0],
//   {4'h0,torque[11:8]}, torque[7:0].
//   Bytes come from the snapshot only. Input changes after launch do not affect the packet.
//  Frame per byte: start(0), d0..d7 (LSB first), stop(1). Each bit is held exactly BAUD_DIV clocks.
//   A byte is 10*BAUD_DIV clocks.
//  Byte to byte: no idle gap. The start bit of byte k+1 begins on the clock after byte k's stop bit ends.
//  State machine (2 states):
//   IDLE -> XMIT on launch.
//   XMIT: baud cnt counts 0..BAUD_DIV-1. At BAUD_DIV-1 it wraps and bit cnt increments (0..9).
//   At bit 9 end with idx<7: idx++, bit cnt=0, next byte's start bit is driven.
//   At bit 9 end with idx==7: -> IDLE, TX=1, busy=0, pkt_done=1 for that single cycle, idx=0.
//  Packet duration: exactly 80*BAUD_DIV clocks from the launch edge to the pkt_done edge. busy is high for exactly that span.
//  en deasserted mid-packet: the current packet completes normally; no further launches.
//  PERIOD < 80*BAUD_DIV is legal. Ticks falling inside a packet are dropped, so packets never overlap.
//  In the pkt_done cycle state is IDLE. A tick in that same cycle launches (back-to-back packets allowed).
//  TX is a registered output, glitch-free. TX is 1 whenever state==IDLE.
// TESTING
//  Bench settings: BAUD_DIV=4, PERIOD=400. Decode TX with UART_rcv, or sample at bit centres.
//  1. batt=ABC, curr=123, torque=7FF, en=1 from reset.
//     -> First start bit falls at clock 400 after reset release.
//     -> Bytes decode AA 55 0A BC 01 23 07 FF.
//     -> pkt_done pulses once, 320 clocks after launch.
//  2. Same packet, then change all inputs to 000 at clock 40 of the packet.
//     -> Received bytes are still 0A BC 01 23 07 FF.
//     -> The next packet carries 00s.
//  3. Bit timing: check start bit low for exactly 4 clocks and stop bits high for 4 clocks.
//     Check the next start bit immediately follows (no gap), and busy=1 for exactly 320 clocks.
//  4. en=0 for 3 periods -> TX constant 1, busy=0.
//     Drop en mid-packet -> that packet completes; no packet on the next tick.
//  5. Assert rst during byte 3 data bits.
//     -> TX=1 and busy=0 before the next clk edge.
//     -> After release, the next launch is 400 clocks later with a fresh snapshot.
//  6. PERIOD=200 (shorter than a packet).
//     -> Packets start only on ticks that land in IDLE (every 2nd tick, 400 clocks apart); never overlapping.

Source files
------------

// File: rtl/telemetry_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : telemetry_tx                                                    |
// | Purpose  : periodic battery/current/torque snapshot framed as an 8-byte    |
// |            packet and sent over an 8N1 UART on TX                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module telemetry_tx #(
  parameter int BAUD_DIV = 5208,
  parameter int PERIOD   = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int c_timer_w = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int c_baud_w  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [c_timer_w-1:0] c_timer_max     = c_timer_w'(PERIOD - 1);
  localparam logic [c_baud_w-1:0]  c_baud_max      = c_baud_w'(BAUD_DIV - 1);
  localparam logic [3:0]           c_bit_last_data = 4'd8;
  localparam logic [3:0]           c_bit_stop      = 4'd9;
  localparam logic [2:0]           c_idx_last      = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_t;

  state_t               state_q;
  logic [c_timer_w-1:0] timer_q;
  logic [c_baud_w-1:0]  baud_q;
  logic [3:0]           bit_q;
  logic [2:0]           idx_q;
  logic [11:0]          batt_q;
  logic [11:0]          curr_q;
  logic [11:0]          torque_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 pkt_done_q;

  logic                 w_tick;
  logic                 w_launch;
  logic [7:0]           w_byte;
  logic                 w_next_bit;

  assign w_tick   = (timer_q == c_timer_max);
  assign w_launch = w_tick & en & (state_q == IDLE);

  // Launch timer runs regardless of link activity so packet spacing stays fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (w_tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batt_q   <= '0;
      curr_q   <= '0;
      torque_q <= '0;
    end else if (w_launch) begin
      batt_q   <= batt;
      curr_q   <= curr;
      torque_q <= torque;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (idx_q)
      3'd0:    w_byte = 8'hAA;
      3'd1:    w_byte = 8'h55;
      3'd2:    w_byte = {4'h0, batt_q[11:8]};
      3'd3:    w_byte = batt_q[7:0];
      3'd4:    w_byte = {4'h0, curr_q[11:8]};
      3'd5:    w_byte = curr_q[7:0];
      3'd6:    w_byte = {4'h0, torque_q[11:8]};
      default: w_byte = torque_q[7:0];
    endcase
  end

  // Level of the bit that follows bit_q: data bits LSB first, then the stop bit.
  assign w_next_bit = (bit_q == c_bit_last_data) ? 1'b1 : w_byte[bit_q[2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (w_launch) begin
            state_q <= XMIT;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
          end
        end
        XMIT: begin
          if (baud_q != c_baud_max) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bit_q != c_bit_stop) begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= w_next_bit;
            end else if (idx_q != c_idx_last) begin
              // Next byte's start bit follows the stop bit with no idle gap.
              idx_q <= idx_q + 1'b1;
              bit_q <= '0;
              tx_q  <= 1'b0;
            end else begin
              state_q    <= IDLE;
              tx_q       <= 1'b1;
              busy_q     <= 1'b0;
              pkt_done_q <= 1'b1;
              idx_q      <= '0;
              bit_q      <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule
`default_nettype wire
